rsfq_gaten_clk_emu: RTL and testbench

RSFQ_GATEN_CLK_EMU -- requirements
Module: rsfq_gaten_clk_emu

---
 rtl/rsfq_gaten_clk_emu.sv | 141 ++++++++++++++
 tb/tb_rsfq_gaten_clk_emu.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rsfq_gaten_clk_emu.sv
// Purpose : cycle-level emulation of a clocked RSFQ N-input gate with toggle-encoded pulses.
// Latency : LAT clk cycles from the sclk pulse to the q toggle / q_pls strobe.
// Backpressure: none; every input transition is consumed and nothing can be stalled.
//
// Ports:
//   clk       single sampling clock, rising edge
//   rst_n     synchronous active-low reset
//   a_tgl     N toggle-encoded data inputs (each transition is one pulse)
//   sclk_tgl  toggle-encoded RSFQ clock input
//   q         toggle-encoded result, inverts once per output pulse
//   q_pls     one-cycle strobe coincident with each q toggle
//   arrived   per-input stored-pulse state
//   viol      one-cycle hold-violation strobe, same cycle as the offending data pulse
//   viol_cnt  saturating violation count
//   ready     high once the post-reset init period has elapsed
module rsfq_gaten_clk_emu #(
   parameter int N        = 2,
   parameter int MODE     = 0,
   parameter int LAT      = 3,
   parameter int HOLD_CYC = 2,
   parameter int INIT_CYC = 8,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     a_tgl,
   input  logic             sclk_tgl,
   output logic             q,
   output logic             q_pls,
   output logic [N-1:0]     arrived,
   output logic             viol,
   output logic [CNT_W-1:0] viol_cnt,
   output logic             ready
);

   localparam int             IW        = (INIT_CYC < 2) ? 1 : $clog2(INIT_CYC + 1);
   localparam logic [IW-1:0]  INIT_LAST = IW'((INIT_CYC == 0) ? 0 : INIT_CYC - 1);
   localparam logic [3:0]     HOLD_V    = 4'(HOLD_CYC);
   localparam logic [3:0]     HALF      = 4'(N / 2);

   logic [N-1:0]  a_prev;
   logic          s_prev;
   logic [N-1:0]  a_pls;
   logic          s_pls;
   logic [N-1:0]  eval_vec;
   logic [3:0]    pop;
   logic          func;
   logic          fire;
   logic [3:0]    hold_cnt;
   logic          in_hold;
   logic          viol_raw;
   logic [IW-1:0] init_cnt;
   logic [LAT-1:0] pipe;
   logic [LAT:0]   chain;

   // A pulse is any difference from the value seen on the previous edge.
   assign a_pls    = a_tgl ^ a_prev;
   assign s_pls    = sclk_tgl ^ s_prev;

   // Data pulses coincident with the clock pulse join the current evaluation.
   assign eval_vec = arrived | a_pls;
   assign in_hold  = (hold_cnt != 4'd0);

   always_comb begin
      pop = 4'd0;
      for (int i = 0; i < N; i++) begin
         pop = pop + {3'b000, eval_vec[i]};
      end
   end

   // An all-zero evaluation gives 0 in every mode (MAJ needs pop > N/2 >= 1).
   always_comb begin
      func = 1'b0;
      case (MODE)
         0:       func = &eval_vec;
         1:       func = |eval_vec;
         2:       func = ^eval_vec;
         3:       func = (pop > HALF);
         default: func = 1'b0;
      endcase
   end

   assign fire = ready & s_pls & func;

   // Same-cycle data pulses always violate; inside the hold window only a
   // pulse that actually gets stored violates (repeats on a set bit are absorbed).
   assign viol_raw = ready & ((s_pls & (|a_pls)) |
                              (~s_pls & in_hold & (|(a_pls & ~arrived))));
   assign viol     = rst_n & viol_raw;

   // chain[k] is the input of pipe stage k; q flips as the last stage loads,
   // so q and q_pls change together.
   assign chain = {pipe, fire};
   assign q_pls = pipe[LAT-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_prev   <= a_tgl;
         s_prev   <= sclk_tgl;
         init_cnt <= '0;
         ready    <= 1'b0;
         arrived  <= '0;
         hold_cnt <= 4'd0;
         pipe     <= '0;
         q        <= 1'b0;
         viol_cnt <= '0;
      end else begin
         // History keeps tracking during init so no stale pulse appears at ready.
         a_prev <= a_tgl;
         s_prev <= sclk_tgl;

         if (!ready) begin
            if (init_cnt == INIT_LAST) begin
               ready <= 1'b1;
            end else begin
               init_cnt <= init_cnt + IW'(1);
            end
         end

         pipe <= chain[LAT-1:0];
         q    <= q ^ chain[LAT-1];

         if (ready) begin
            if (s_pls) begin
               arrived  <= '0;
               hold_cnt <= HOLD_V;
            end else begin
               arrived <= arrived | a_pls;
               if (in_hold) begin
                  hold_cnt <= hold_cnt - 4'd1;
               end
            end
         end

         if (viol_raw && (viol_cnt != {CNT_W{1'b1}})) begin
            viol_cnt <= viol_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_rsfq_gaten_clk_emu.sv
// Purpose : directed checks of the clocked-gate emulator across four configurations.
// Latency : n/a (bench).
// Backpressure: n/a (bench).
module tb_rsfq_gaten_clk_emu;

   logic clk;
   logic rst_n;

   // d0: N=2 AND, default timing
   logic [1:0] a0;
   logic       s0, q0, qp0, v0, r0;
   logic [1:0] ar0;
   logic [7:0] vc0;
   // d1: N=3 MAJ
   logic [2:0] a1;
   logic       s1, q1, qp1, v1, r1;
   logic [2:0] ar1;
   logic [7:0] vc1;
   // d2: N=4 XOR
   logic [3:0] a2;
   logic       s2, q2, qp2, v2, r2;
   logic [3:0] ar2;
   logic [7:0] vc2;
   // d3: N=2 AND, 2-bit violation counter
   logic [1:0] a3;
   logic       s3, q3, qp3, v3, r3;
   logic [1:0] ar3;
   logic [1:0] vc3;

   int checks   = 0;
   int failures = 0;

   rsfq_gaten_clk_emu #(.N(2), .MODE(0), .LAT(3), .HOLD_CYC(2), .INIT_CYC(8), .CNT_W(8)) d0 (
      .clk(clk), .rst_n(rst_n), .a_tgl(a0), .sclk_tgl(s0), .q(q0), .q_pls(qp0),
      .arrived(ar0), .viol(v0), .viol_cnt(vc0), .ready(r0));
   rsfq_gaten_clk_emu #(.N(3), .MODE(3), .LAT(3), .HOLD_CYC(2), .INIT_CYC(8), .CNT_W(8)) d1 (
      .clk(clk), .rst_n(rst_n), .a_tgl(a1), .sclk_tgl(s1), .q(q1), .q_pls(qp1),
      .arrived(ar1), .viol(v1), .viol_cnt(vc1), .ready(r1));
   rsfq_gaten_clk_emu #(.N(4), .MODE(2), .LAT(3), .HOLD_CYC(2), .INIT_CYC(8), .CNT_W(8)) d2 (
      .clk(clk), .rst_n(rst_n), .a_tgl(a2), .sclk_tgl(s2), .q(q2), .q_pls(qp2),
      .arrived(ar2), .viol(v2), .viol_cnt(vc2), .ready(r2));
   rsfq_gaten_clk_emu #(.N(2), .MODE(0), .LAT(3), .HOLD_CYC(2), .INIT_CYC(8), .CNT_W(2)) d3 (
      .clk(clk), .rst_n(rst_n), .a_tgl(a3), .sclk_tgl(s3), .q(q3), .q_pls(qp3),
      .arrived(ar3), .viol(v3), .viol_cnt(vc3), .ready(r3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int exp_cnt;
      rst_n = 1'b0;
      a0 = '0; s0 = 1'b0;
      a1 = '0; s1 = 1'b0;
      a2 = '0; s2 = 1'b0;
      a3 = '0; s3 = 1'b0;
      repeat (3) nxt();
      // inputs move under reset: history must absorb them
      a3 = 2'b11;
      s3 = 1'b1;
      nxt();
      rst_n = 1'b1;

      // reset state
      chk("rst_q",       {31'd0, q0},   32'd0);
      chk("rst_q_pls",   {31'd0, qp0},  32'd0);
      chk("rst_arrived", {30'd0, ar0},  32'd0);
      chk("rst_viol",    {31'd0, v0},   32'd0);
      chk("rst_viol_cnt",{24'd0, vc0},  32'd0);
      chk("rst_ready",   {31'd0, r0},   32'd0);

      // pulses during init are discarded
      nxt();
      a3 = 2'b00;
      repeat (6) nxt();
      chk("init_ready_low", {31'd0, r0},  32'd0);
      chk("init_arrived",   {30'd0, ar3}, 32'd0);
      chk("init_viol",      {31'd0, v3},  32'd0);
      nxt();
      chk("init_ready_high", {31'd0, r0},  32'd1);
      chk("init_arrived2",   {30'd0, ar3}, 32'd0);

      // AND true: a0, a1, then sclk
      a0 = 2'b01; nxt();
      chk("and_arr01", {30'd0, ar0}, 32'h1);
      a0 = 2'b11; nxt();
      chk("and_arr11", {30'd0, ar0}, 32'h3);
      s0 = 1'b1; #1;
      chk("and_noviol", {31'd0, v0}, 32'd0);
      nxt();
      chk("and_arr_clr", {30'd0, ar0}, 32'h0);
      chk("and_q_t1",    {31'd0, q0},  32'd0);
      nxt();
      chk("and_q_t2",    {31'd0, q0},  32'd0);
      chk("and_qp_t2",   {31'd0, qp0}, 32'd0);
      nxt();
      chk("and_q_t3",    {31'd0, q0},  32'd1);
      chk("and_qp_t3",   {31'd0, qp0}, 32'd1);
      nxt();
      chk("and_qp_t4",   {31'd0, qp0}, 32'd0);

      // AND false: only a0, then an empty sclk
      a0 = 2'b10; nxt();
      chk("andf_arr01", {30'd0, ar0}, 32'h1);
      s0 = 1'b0; nxt();
      chk("andf_arr00", {30'd0, ar0}, 32'h0);
      nxt(); nxt();
      chk("andf_q",  {31'd0, q0},  32'd1);
      chk("andf_qp", {31'd0, qp0}, 32'd0);
      s0 = 1'b1; nxt(); nxt(); nxt();
      chk("empty_q",  {31'd0, q0},  32'd1);
      chk("empty_qp", {31'd0, qp0}, 32'd0);
      chk("empty_viol_cnt", {24'd0, vc0}, 32'd0);

      // MAJ N=3: 2 of 3 fires, 1 of 3 does not
      a1 = 3'b101; nxt();
      chk("maj_arr101", {29'd0, ar1}, 32'h5);
      s1 = 1'b1; nxt();
      chk("maj_arr_clr", {29'd0, ar1}, 32'h0);
      nxt(); nxt();
      chk("maj_q",  {31'd0, q1},  32'd1);
      chk("maj_qp", {31'd0, qp1}, 32'd1);
      nxt(); nxt();
      a1 = 3'b100; nxt();
      chk("maj1_arr001", {29'd0, ar1}, 32'h1);
      s1 = 1'b0; nxt(); nxt(); nxt();
      chk("maj1_q",  {31'd0, q1},  32'd1);
      chk("maj1_qp", {31'd0, qp1}, 32'd0);

      // XOR N=4: hold-window violation stores the pulse for the next period
      s2 = 1'b1; nxt();
      a2 = 4'b0001; #1;
      chk("hold_viol", {31'd0, v2}, 32'd1);
      nxt();
      chk("hold_viol_off", {31'd0, v2},  32'd0);
      chk("hold_viol_cnt", {24'd0, vc2}, 32'd1);
      chk("hold_arr",      {28'd0, ar2}, 32'h1);
      nxt(); nxt();
      s2 = 1'b0; nxt();
      chk("xor_arr_clr", {28'd0, ar2}, 32'h0);
      nxt(); nxt();
      chk("xor_q",  {31'd0, q2},  32'd1);
      chk("xor_qp", {31'd0, qp2}, 32'd1);
      // same-cycle data + sclk: counts toward evaluation and violates
      a2 = 4'b0011; s2 = 1'b1; #1;
      chk("same_viol", {31'd0, v2}, 32'd1);
      nxt();
      chk("same_viol_cnt", {24'd0, vc2}, 32'd2);
      chk("same_arr",      {28'd0, ar2}, 32'h0);
      // two violating inputs in one cycle -> one increment
      a2 = 4'b1111; #1;
      chk("multi_viol", {31'd0, v2}, 32'd1);
      nxt();
      chk("multi_viol_cnt", {24'd0, vc2}, 32'd3);
      chk("multi_arr",      {28'd0, ar2}, 32'hc);
      nxt();
      chk("same_fire_q",  {31'd0, q2},  32'd0);
      chk("same_fire_qp", {31'd0, qp2}, 32'd1);
      // even popcount -> no output; pulse 3 cycles later is outside the window
      s2 = 1'b0; nxt(); nxt(); nxt();
      chk("even_qp", {31'd0, qp2}, 32'd0);
      a2 = 4'b1101; #1;
      chk("edge_noviol", {31'd0, v2}, 32'd0);
      nxt();
      chk("edge_viol_cnt", {24'd0, vc2}, 32'd3);
      chk("edge_arr",      {28'd0, ar2}, 32'h2);

      // 2-bit counter saturates
      for (int k = 1; k <= 5; k++) begin
         a3 = a3 ^ 2'b01;
         s3 = ~s3;
         #1;
         chk("sat_viol", {31'd0, v3}, 32'd1);
         nxt();
         exp_cnt = (k < 3) ? k : 3;
         chk("sat_cnt", {30'd0, vc3}, exp_cnt);
      end
      nxt(); nxt();
      chk("sat_q", {31'd0, q3}, 32'd0);

      // reset one cycle after an AND-true sclk pulse
      a0 = 2'b01; nxt();
      chk("mid_arr11", {30'd0, ar0}, 32'h3);
      s0 = 1'b0; nxt();
      rst_n = 1'b0;
      a0 = 2'b10;
      s0 = 1'b1;
      nxt();
      chk("mid_rst_q",   {31'd0, q0},  32'd0);
      chk("mid_rst_qp",  {31'd0, qp0}, 32'd0);
      chk("mid_rst_arr", {30'd0, ar0}, 32'h0);
      nxt();
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         nxt();
         chk("mid_post_q",  {31'd0, q0},  32'd0);
         chk("mid_post_qp", {31'd0, qp0}, 32'd0);
      end
      chk("mid_post_arr",   {30'd0, ar0}, 32'h0);
      chk("mid_post_viol",  {31'd0, v0},  32'd0);
      chk("mid_post_vcnt",  {24'd0, vc0}, 32'd0);
      chk("mid_post_ready", {31'd0, r0},  32'd1);
      chk("mid_post_vc3",   {30'd0, vc3}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
